// File: rtl/finish_aggregator.sv
// finish_aggregator: sticky per-PU finish capture with masked all-finished
// detection, a one-cycle done pulse per iteration and a wrapping iteration
// counter. AUTO_CLEAR=1 drops all finish bits the cycle after each pulse.
// Optional watchdog: define FINISH_AGG_TIMEOUT_EN to add the timeout_cycles
// input, the sticky timeout_flag output and the cycle counter behind them.
module finish_aggregator #(
    parameter int N_PU       = 8,
    parameter int ITER_W     = 16,
    parameter int AUTO_CLEAR = 0,
    parameter int TIMEOUT_W  = 24
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         clear_finish_reg,
    input  logic [N_PU-1:0]              set_finish,
    input  logic [N_PU-1:0]              pu_enable_mask,
    output logic [N_PU-1:0]              finish_reg,
    output logic [$clog2(N_PU+1)-1:0]    finish_count,
    output logic                         all_finished,
    output logic                         done_pulse,
    output logic [ITER_W-1:0]            iteration_count
`ifdef FINISH_AGG_TIMEOUT_EN
    ,
    input  logic [TIMEOUT_W-1:0]         timeout_cycles,
    output logic                         timeout_flag
`endif
);

    localparam int CNT_W = $clog2(N_PU + 1);

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_DONE = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [N_PU-1:0]     finish_q, finish_d;
    logic                done_pulse_q, done_pulse_d;
    logic [ITER_W-1:0]   iter_q, iter_d;
    logic [N_PU-1:0]     masked_finish;
    logic                clear_any;
    logic                run_to_done;
    logic [CNT_W-1:0]    count_sum;

    // Auto-clear acts exactly like a host clear, one cycle after the pulse.
    assign clear_any   = clear_finish_reg || ((AUTO_CLEAR != 0) && (state_q == ST_DONE));
    assign run_to_done = (state_q == ST_RUN) && all_finished && !clear_finish_reg;

    // Per-bit capture: clear beats a coincident set, so the PU must re-assert.
    genvar gi;
    generate
        for (gi = 0; gi < N_PU; gi++) begin : g_bit
            assign finish_d[gi]      = clear_any ? 1'b0 : (finish_q[gi] | set_finish[gi]);
            assign masked_finish[gi] = finish_q[gi] & pu_enable_mask[gi];
        end
    endgenerate

    // Popcount of the enabled finished PUs.
    always_comb begin
        count_sum = '0;
        for (int i = 0; i < N_PU; i++) begin
            count_sum = count_sum + CNT_W'(masked_finish[i]);
        end
    end

    // An empty mask never completes; otherwise every enabled PU must be done.
    assign all_finished    = (pu_enable_mask != '0) && (masked_finish == pu_enable_mask);
    assign finish_count    = count_sum;
    assign finish_reg      = finish_q;
    assign done_pulse      = done_pulse_q;
    assign iteration_count = iter_q;

    // Next-state for the RUN/DONE iteration FSM, pulse and iteration counter.
    always_comb begin
        state_d      = state_q;
        done_pulse_d = 1'b0;
        iter_d       = iter_q;
        if (clear_finish_reg) begin
            state_d = ST_RUN;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (all_finished) begin
                        state_d      = ST_DONE;
                        done_pulse_d = 1'b1;
                        iter_d       = iter_q + ITER_W'(1);
                    end
                end
                ST_DONE: begin
                    if (AUTO_CLEAR != 0) begin
                        state_d = ST_RUN;
                    end
                end
                default: state_d = ST_RUN;
            endcase
        end
    end

    // State, capture bits, pulse and iteration counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_RUN;
            finish_q     <= '0;
            done_pulse_q <= 1'b0;
            iter_q       <= '0;
        end else begin
            state_q      <= state_d;
            finish_q     <= finish_d;
            done_pulse_q <= done_pulse_d;
            iter_q       <= iter_d;
        end
    end

`ifdef FINISH_AGG_TIMEOUT_EN
    logic [TIMEOUT_W-1:0] wd_q, wd_d;
    logic                 timeout_flag_q, timeout_flag_d;

    // Watchdog restarts on clear or completion, counts while in RUN, saturates.
    always_comb begin
        wd_d           = wd_q;
        timeout_flag_d = timeout_flag_q;
        if (clear_finish_reg || run_to_done) begin
            wd_d = '0;
        end else if ((state_q == ST_RUN) && (wd_q != '1)) begin
            wd_d = wd_q + TIMEOUT_W'(1);
        end
        if (clear_finish_reg) begin
            timeout_flag_d = 1'b0;
        end else if ((timeout_cycles != '0) && (wd_q == timeout_cycles)) begin
            timeout_flag_d = 1'b1;
        end
    end

    // Watchdog counter and sticky flag registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            wd_q           <= '0;
            timeout_flag_q <= 1'b0;
        end else begin
            wd_q           <= wd_d;
            timeout_flag_q <= timeout_flag_d;
        end
    end

    assign timeout_flag = timeout_flag_q;
`else
    logic unused_run_to_done;
    assign unused_run_to_done = run_to_done;
`endif

endmodule

// File: tb/tb_finish_aggregator.sv
// Bench for finish_aggregator: three instances (manual clear, ITER_W=2 sharing
// the same stimulus, AUTO_CLEAR=1). Expected iteration counts are queued when
// the completing stimulus is driven and popped when a done pulse appears.
module tb_finish_aggregator;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       clr_a, clr_c;
    logic [3:0] set_a, mask_a, set_c, mask_c;

    logic [3:0]  finish_a, finish_w, finish_c;
    logic [2:0]  count_a, count_w, count_c;
    logic        af_a, af_w, af_c;
    logic        pulse_a, pulse_w, pulse_c;
    logic [15:0] iter_a, iter_c;
    logic [1:0]  iter_w;
`ifdef FINISH_AGG_TIMEOUT_EN
    logic [23:0] tc_a, tc_zero;
    logic        tflag_a, tflag_w, tflag_c;
`endif

    finish_aggregator #(.N_PU(4), .ITER_W(16), .AUTO_CLEAR(0), .TIMEOUT_W(24)) dut_a (
        .clk(clk), .reset(reset), .clear_finish_reg(clr_a), .set_finish(set_a),
        .pu_enable_mask(mask_a), .finish_reg(finish_a), .finish_count(count_a),
        .all_finished(af_a), .done_pulse(pulse_a), .iteration_count(iter_a)
`ifdef FINISH_AGG_TIMEOUT_EN
        , .timeout_cycles(tc_a), .timeout_flag(tflag_a)
`endif
    );

    finish_aggregator #(.N_PU(4), .ITER_W(2), .AUTO_CLEAR(0), .TIMEOUT_W(24)) dut_w (
        .clk(clk), .reset(reset), .clear_finish_reg(clr_a), .set_finish(set_a),
        .pu_enable_mask(mask_a), .finish_reg(finish_w), .finish_count(count_w),
        .all_finished(af_w), .done_pulse(pulse_w), .iteration_count(iter_w)
`ifdef FINISH_AGG_TIMEOUT_EN
        , .timeout_cycles(tc_zero), .timeout_flag(tflag_w)
`endif
    );

    finish_aggregator #(.N_PU(4), .ITER_W(16), .AUTO_CLEAR(1), .TIMEOUT_W(24)) dut_c (
        .clk(clk), .reset(reset), .clear_finish_reg(clr_c), .set_finish(set_c),
        .pu_enable_mask(mask_c), .finish_reg(finish_c), .finish_count(count_c),
        .all_finished(af_c), .done_pulse(pulse_c), .iteration_count(iter_c)
`ifdef FINISH_AGG_TIMEOUT_EN
        , .timeout_cycles(tc_zero), .timeout_flag(tflag_c)
`endif
    );

    int n_cmp = 0;
    int n_bad = 0;
    int q_a[$];
    int q_w[$];
    int q_c[$];
    int exp_a = 0;
    int exp_c = 0;
    logic prev_a = 1'b0, prev_w = 1'b0, prev_c = 1'b0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end else begin
            $display("ok   %s: %0h", tag, obs);
        end
    endtask

    // One clock; pulses are matched against the scoreboard queues.
    task automatic step();
        @(posedge clk);
        #1;
        check_val("pulse_a_twice", pulse_a & prev_a, 0);
        check_val("pulse_w_twice", pulse_w & prev_w, 0);
        check_val("pulse_c_twice", pulse_c & prev_c, 0);
        if (pulse_a) begin
            check_val("pulse_a_expected", pulse_a, q_a.size() != 0);
            if (q_a.size() != 0) check_val("iter_a", iter_a, q_a.pop_front());
        end
        if (pulse_w) begin
            check_val("pulse_w_expected", pulse_w, q_w.size() != 0);
            if (q_w.size() != 0) check_val("iter_w", iter_w, q_w.pop_front());
        end
        if (pulse_c) begin
            check_val("pulse_c_expected", pulse_c, q_c.size() != 0);
            if (q_c.size() != 0) check_val("iter_c", iter_c, q_c.pop_front());
        end
        prev_a = pulse_a;
        prev_w = pulse_w;
        prev_c = pulse_c;
    endtask

    task automatic expect_done_a();
        exp_a++;
        q_a.push_back(exp_a & 16'hFFFF);
        q_w.push_back(exp_a & 3);
    endtask

    task automatic clear_a();
        clr_a = 1'b1;
        set_a = 4'h0;
        step();
        clr_a = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        clr_a = 1'b0; set_a = 4'h0; mask_a = 4'h0;
        clr_c = 1'b0; set_c = 4'h0; mask_c = 4'h0;
`ifdef FINISH_AGG_TIMEOUT_EN
        tc_a = '0; tc_zero = '0;
`endif
        step();
        step();
        check_val("rst_finish_a", finish_a, 0);
        check_val("rst_pulse_a", pulse_a, 0);
        check_val("rst_iter_a", iter_a, 0);
        check_val("rst_af_a", af_a, 0);
        check_val("rst_iter_w", iter_w, 0);
        check_val("rst_finish_c", finish_c, 0);
`ifdef FINISH_AGG_TIMEOUT_EN
        check_val("rst_tflag_a", tflag_a, 0);
`endif
        reset = 1'b0;

        // Staggered single-bit finishes, full mask.
        mask_a = 4'hF;
        for (int c = 1; c <= 10; c++) begin
            case (c)
                1: set_a = 4'b0001;
                3: set_a = 4'b0010;
                5: set_a = 4'b0100;
                7: set_a = 4'b1000;
                default: set_a = 4'b0000;
            endcase
            if (c == 7) expect_done_a();
            step();
            check_val("t1_pulse", pulse_a, c == 8);
            check_val("t1_count", count_a, (c >= 7) ? 4 : (c + 1) / 2);
        end
        set_a = 4'h0;
        check_val("t1_finish", finish_a, 4'hF);
        check_val("t1_af", af_a, 1);
        check_val("t1_iter", iter_a, 1);
        // DONE holds without further pulses.
        set_a = 4'hF;
        for (int i = 0; i < 3; i++) step();
        set_a = 4'h0;
        check_val("t1_hold_iter", iter_a, 1);

        // Partial masks.
        clear_a();
        check_val("t2_clr_finish", finish_a, 0);
        check_val("t2_clr_af", af_a, 0);
        mask_a = 4'b0101; set_a = 4'b0101; expect_done_a();
        step();
        set_a = 4'h0;
        check_val("t2_af", af_a, 1);
        check_val("t2_count", count_a, 2);
        step();
        check_val("t2_pulse1", pulse_a, 1);
        clear_a();
        mask_a = 4'b0010; set_a = 4'b0010; expect_done_a();
        step();
        set_a = 4'h0;
        step();
        check_val("t2_pulse2", pulse_a, 1);
        clear_a();
        mask_a = 4'b0000; set_a = 4'hF;
        step();
        set_a = 4'h0;
        step();
        step();
        check_val("t2_mask0_finish", finish_a, 4'hF);
        check_val("t2_mask0_af", af_a, 0);
        check_val("t2_mask0_count", count_a, 0);
        check_val("t2_mask0_iter", iter_a, exp_a);

        // Dropping the last unfinished PU from the mask completes the iteration.
        clear_a();
        mask_a = 4'hF; set_a = 4'b0111;
        step();
        set_a = 4'h0;
        check_val("t2_drop_af0", af_a, 0);
        check_val("t2_drop_count", count_a, 3);
        mask_a = 4'b0111;
        #1;
        check_val("t2_drop_af1", af_a, 1);
        expect_done_a();
        step();
        step();
        check_val("t2_drop_iter", iter_a, exp_a);

        // Clear coincident with the completing set drops the set.
        clear_a();
        mask_a = 4'hF; set_a = 4'b0111;
        step();
        set_a = 4'b1000; clr_a = 1'b1;
        step();
        clr_a = 1'b0; set_a = 4'h0;
        check_val("t3_finish", finish_a, 0);
        check_val("t3_pulse", pulse_a, 0);
        check_val("t3_af", af_a, 0);
        step();
        check_val("t3_pulse_next", pulse_a, 0);
        check_val("t3_iter", iter_a, exp_a);
        // Clear in the cycle all_finished first rises: no pulse.
        set_a = 4'hF;
        step();
        set_a = 4'h0;
        check_val("t3_af_rise", af_a, 1);
        clr_a = 1'b1;
        step();
        clr_a = 1'b0;
        check_val("t3_rise_pulse", pulse_a, 0);
        step();
        check_val("t3_rise_pulse_next", pulse_a, 0);
        check_val("t3_rise_iter", iter_a, exp_a);

        // More completions to wrap the 2-bit counter.
        for (int k = 0; k < 3; k++) begin
            clear_a();
            set_a = 4'hF; expect_done_a();
            step();
            set_a = 4'h0;
            step();
            check_val("w_pulse", pulse_w, 1);
            check_val("w_iter", iter_w, exp_a % 4);
        end

        // Reset mid-run.
        clear_a();
        set_a = 4'b0011;
        step();
        set_a = 4'h0;
        check_val("r_finish_pre", finish_a, 4'b0011);
        reset = 1'b1;
        step();
        check_val("r_finish_a", finish_a, 0);
        check_val("r_count_a", count_a, 0);
        check_val("r_af_a", af_a, 0);
        check_val("r_pulse_a", pulse_a, 0);
        check_val("r_iter_a", iter_a, 0);
        check_val("r_iter_w", iter_w, 0);
        check_val("r_finish_w", finish_w, 0);
        reset = 1'b0;
        exp_a = 0;
        q_a.delete();
        q_w.delete();

        // Auto-clear: three back-to-back iterations.
        mask_c = 4'hF;
        for (int k = 0; k < 3; k++) begin
            set_c = 4'hF;
            exp_c++;
            q_c.push_back(exp_c);
            step();
            set_c = 4'h0;
            check_val("c_finish_set", finish_c, 4'hF);
            step();
            check_val("c_pulse", pulse_c, 1);
            check_val("c_finish_at_pulse", finish_c, 4'hF);
            step();
            check_val("c_finish_cleared", finish_c, 0);
            check_val("c_pulse_low", pulse_c, 0);
        end
        check_val("c_iter", iter_c, 3);

`ifdef FINISH_AGG_TIMEOUT_EN
        // Watchdog: limit 10, only bit 0 finishes.
        tc_a = 24'd10;
        mask_a = 4'hF;
        clear_a();
        set_a = 4'b0001;
        for (int k = 1; k <= 14; k++) begin
            step();
            set_a = 4'h0;
            check_val("to_flag", tflag_a, k >= 11);
        end
        clear_a();
        check_val("to_flag_cleared", tflag_a, 0);
`endif

        check_val("pending_a", q_a.size(), 0);
        check_val("pending_w", q_w.size(), 0);
        check_val("pending_c", q_c.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
